// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the forwarding scoreboard: in-flight slot entry,
// forward-select width and the register-file select encoding.
package fwd_scoreboard_pkg;

  // Widest register address a slot entry can hold; narrower addresses are zero-extended.
  localparam int MAX_ADDR_W = 8;
  localparam int SEL_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  function automatic int sel_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage issue request and EX forwarding/stall response bundle of the scoreboard.
interface fwd_scoreboard_if
  import fwd_scoreboard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
);
  localparam int SELW = sel_width(DEPTH);

  logic                      issue_valid_i;
  logic [ADDR_W-1:0]         issue_rd_i;
  logic                      issue_regwrite_i;
  logic                      issue_load_i;
  logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
  logic                      hold_i;
  logic                      flush_i;
  logic                      stall_o;
  logic [NUM_SRC*SELW-1:0]   fwd_sel_o;
  logic [15:0]               stall_cnt_o;

  modport master (
    output issue_valid_i, issue_rd_i, issue_regwrite_i, issue_load_i,
           src_addr_i, hold_i, flush_i,
    input  stall_o, fwd_sel_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i, issue_regwrite_i, issue_load_i,
           src_addr_i, hold_i, flush_i,
    output stall_o, fwd_sel_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_src_match.sv
// Youngest-producer search for one source operand: yields the forward select
// and whether that producer is a load whose data is not yet forwardable.
module fwd_src_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = sel_width(DEPTH)
) (
  input  slot_t [DEPTH-1:0] slots_i,
  input  logic [ADDR_W-1:0] src_i,
  output logic [SELW-1:0]   sel_o,
  output logic              load_hazard_o
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_o         = SELW'(SEL_RF);
    load_hazard_o = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (slots_i[k-1].valid && slots_i[k-1].regwrite &&
          (slots_i[k-1].rd == MAX_ADDR_W'(src_i)) && (src_i != '0)) begin
        sel_o         = (k <= DEPTH - 1) ? SELW'(k) : SELW'(SEL_RF);
        load_hazard_o = slots_i[k-1].load && (k < 1 + LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight instruction scoreboard: tracks EX and later producers, generates
// registered operand-forwarding selects and the load-use stall for ID.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fwd_scoreboard_if.slave  bus
);

  localparam int SELW = sel_width(DEPTH);

  slot_t [DEPTH-1:0]       slots_q, slots_d;
  logic [NUM_SRC*SELW-1:0] fwd_sel_q, fwd_sel_d, sel_vec;
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]      hazard;
  logic                    stall, accept;
  slot_t                   issue_entry;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_src_match #(
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .LOAD_LAT(LOAD_LAT),
      .SELW    (SELW)
    ) u_match (
      .slots_i      (slots_q),
      .src_i        (bus.src_addr_i[gi*ADDR_W +: ADDR_W]),
      .sel_o        (sel_vec[gi*SELW +: SELW]),
      .load_hazard_o(hazard[gi])
    );
  end

  assign stall  = bus.issue_valid_i & ~bus.flush_i & (|hazard);
  assign accept = bus.issue_valid_i & ~stall & ~bus.hold_i & ~bus.flush_i;

  always_comb begin
    issue_entry          = SLOT_EMPTY;
    issue_entry.valid    = 1'b1;
    issue_entry.rd       = MAX_ADDR_W'(bus.issue_rd_i);
    issue_entry.regwrite = bus.issue_regwrite_i;
    issue_entry.load     = bus.issue_load_i;
  end

  // A flush squashes the EX instruction before it moves to slot 2; hold freezes everything.
  always_comb begin
    slots_d     = slots_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.hold_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      if (bus.flush_i) begin
        slots_d[1].valid = 1'b0;
      end
      slots_d[0] = accept ? issue_entry : SLOT_EMPTY;
      fwd_sel_d  = accept ? sel_vec : '0;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q     <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.fwd_sel_o   = fwd_sel_q;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard at default parameters
// (ADDR_W=5, NUM_SRC=2, DEPTH=3, LOAD_LAT=1); fwd_sel is {sel_src1, sel_src0}.
module tb_fwd_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  fwd_scoreboard_if #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3)) bus ();

  fwd_scoreboard #(
    .ADDR_W  (5),
    .NUM_SRC (2),
    .DEPTH   (3),
    .LOAD_LAT(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic rw,
                               input logic ld, input logic [4:0] s0, input logic [4:0] s1);
    bus.issue_valid_i    = v;
    bus.issue_rd_i       = rd;
    bus.issue_regwrite_i = rw;
    bus.issue_load_i     = ld;
    bus.src_addr_i       = {s1, s0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic consume(input logic [4:0] s0, input logic [4:0] s1);
    applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, s0, s1);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (3) cycle();
  endtask

  initial begin
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    checkOutput("reset_sel", 16'(bus.fwd_sel_o), 16'h0);
    checkOutput("reset_cnt", bus.stall_cnt_o, 16'h0);
    checkOutput("reset_stall", 16'(bus.stall_o), 16'h0);

    // distance-1 forward
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    consume(5'd3, 5'd0);
    checkOutput("d1_stall", 16'(bus.stall_o), 16'h0);
    cycle();
    checkOutput("d1_sel", 16'(bus.fwd_sel_o), 16'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    cycle();
    checkOutput("bubble_sel", 16'(bus.fwd_sel_o), 16'h0);
    drain();

    // distance-2 forward to both sources
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 5'd1, 5'd2);
    cycle();
    consume(5'd3, 5'd3);
    checkOutput("d2_stall", 16'(bus.stall_o), 16'h0);
    cycle();
    checkOutput("d2_sel_both", 16'(bus.fwd_sel_o), 16'hA);
    drain();

    // youngest producer wins
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    consume(5'd3, 5'd0);
    cycle();
    checkOutput("youngest_sel", 16'(bus.fwd_sel_o), 16'h1);
    drain();

    // load-use stall for one cycle
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0);
    cycle();
    consume(5'd0, 5'd4);
    checkOutput("lu_stall", 16'(bus.stall_o), 16'h1);
    cycle();
    checkOutput("lu_sel_bubble", 16'(bus.fwd_sel_o), 16'h0);
    checkOutput("lu_cnt", bus.stall_cnt_o, 16'h1);
    checkOutput("lu_stall_clear", 16'(bus.stall_o), 16'h0);
    cycle();
    checkOutput("lu_sel", 16'(bus.fwd_sel_o), 16'h8);
    checkOutput("lu_cnt_after", bus.stall_cnt_o, 16'h1);
    drain();

    // r0 and non-writing producers never forward
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    consume(5'd0, 5'd0);
    checkOutput("r0_stall", 16'(bus.stall_o), 16'h0);
    cycle();
    checkOutput("r0_sel", 16'(bus.fwd_sel_o), 16'h0);
    drain();
    applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0);
    cycle();
    consume(5'd5, 5'd5);
    checkOutput("nowr_stall", 16'(bus.stall_o), 16'h0);
    cycle();
    checkOutput("nowr_sel", 16'(bus.fwd_sel_o), 16'h0);
    drain();

    // hold freezes slots and select
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    consume(5'd6, 5'd0);
    cycle();
    checkOutput("hold_pre_sel", 16'(bus.fwd_sel_o), 16'h1);
    bus.hold_i = 1'b1;
    consume(5'd6, 5'd0);
    cycle();
    checkOutput("hold_sel_kept", 16'(bus.fwd_sel_o), 16'h1);
    bus.hold_i = 1'b0;
    #1;
    cycle();
    checkOutput("hold_release_sel", 16'(bus.fwd_sel_o), 16'h2);
    drain();

    // stall under hold is not counted
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0);
    cycle();
    bus.hold_i = 1'b1;
    consume(5'd4, 5'd0);
    checkOutput("hold_stall", 16'(bus.stall_o), 16'h1);
    repeat (2) cycle();
    checkOutput("hold_cnt_frozen", bus.stall_cnt_o, 16'h1);
    bus.hold_i = 1'b0;
    #1;
    checkOutput("hold_stall_after", 16'(bus.stall_o), 16'h1);
    cycle();
    checkOutput("hold_cnt_inc", bus.stall_cnt_o, 16'h2);
    cycle();
    checkOutput("hold_lu_sel", 16'(bus.fwd_sel_o), 16'h2);
    drain();

    // flush squashes the load and overrides the stall
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0);
    cycle();
    consume(5'd4, 5'd0);
    checkOutput("fl_stall_pre", 16'(bus.stall_o), 16'h1);
    bus.flush_i = 1'b1;
    #1;
    checkOutput("fl_stall", 16'(bus.stall_o), 16'h0);
    cycle();
    bus.flush_i = 1'b0;
    consume(5'd4, 5'd0);
    checkOutput("fl_stall_post", 16'(bus.stall_o), 16'h0);
    checkOutput("fl_cnt", bus.stall_cnt_o, 16'h2);
    cycle();
    checkOutput("fl_sel_squashed", 16'(bus.fwd_sel_o), 16'h0);
    drain();

    // reset during a stall, with hold asserted
    applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0);
    cycle();
    consume(5'd8, 5'd0);
    cycle();
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b1, 5'd8, 5'd0);
    cycle();
    checkOutput("rs_pre_sel", 16'(bus.fwd_sel_o), 16'h2);
    consume(5'd4, 5'd0);
    checkOutput("rs_pre_stall", 16'(bus.stall_o), 16'h1);
    checkOutput("rs_pre_cnt", bus.stall_cnt_o, 16'h2);
    rst = 1'b1;
    bus.hold_i = 1'b1;
    cycle();
    rst = 1'b0;
    bus.hold_i = 1'b0;
    #1;
    checkOutput("rs_stall", 16'(bus.stall_o), 16'h0);
    checkOutput("rs_sel", 16'(bus.fwd_sel_o), 16'h0);
    checkOutput("rs_cnt", bus.stall_cnt_o, 16'h0);
    cycle();
    checkOutput("rs_accept_sel", 16'(bus.fwd_sel_o), 16'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
